// File: rtl/reg_shift_sequencer.sv
// Multi-cycle sequencer for ARM register-specified shifts (amount from Rs[7:0]).
// Stalls the EX stage while val_Rm is shifted STEP bits per cycle, then
// presents val2 and the shifter carry-out for a single done cycle.
module reg_shift_sequencer #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  shift_type,
    input  logic [31:0] val_Rm,
    input  logic [7:0]  val_Rs,
    input  logic        carry_in,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] val2,
    output logic        carry_out
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    logic [1:0]    state, state_n;
    logic [DW-1:0] work, work_n;
    logic [CW-1:0] count, count_n;
    logic [1:0]    typ, typ_n;
    logic [DW-1:0] val2_n;
    logic          carry_n;

    logic [CW-1:0] amt_n;
    logic [CW-1:0] k;
    logic [DW-1:0] sh_work;
    logic          sh_carry;

    // Clamp Rs[7:0] to the number of single-bit steps that gives ARM semantics
    always_comb begin
        amt_n = CW'(0);
        case (shift_type)
            SH_LSL, SH_LSR: amt_n = (val_Rs > 8'd33) ? CW'(33) : val_Rs[CW-1:0];
            SH_ASR:         amt_n = (val_Rs > 8'd32) ? CW'(32) : val_Rs[CW-1:0];
            default:        amt_n = {1'b0, val_Rs[4:0]};
        endcase
    end

    // One SHIFT cycle: up to STEP single-bit shifts, carry is the last bit out
    always_comb begin
        sh_work  = work;
        sh_carry = 1'b0;
        k        = (count > CW'(STEP)) ? CW'(STEP) : count;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (CW'(i) < k) begin
                case (typ)
                    SH_LSL: begin
                        sh_carry = sh_work[DW-1];
                        sh_work  = {sh_work[DW-2:0], 1'b0};
                    end
                    SH_LSR: begin
                        sh_carry = sh_work[0];
                        sh_work  = {1'b0, sh_work[DW-1:1]};
                    end
                    SH_ASR: begin
                        sh_carry = sh_work[0];
                        sh_work  = {sh_work[DW-1], sh_work[DW-1:1]};
                    end
                    default: begin
                        sh_work  = {sh_work[0], sh_work[DW-1:1]};
                        sh_carry = sh_work[DW-1];
                    end
                endcase
            end
        end
    end

    // Next-state, datapath updates and the combinational stall
    always_comb begin
        state_n = state;
        work_n  = work;
        count_n = count;
        typ_n   = typ;
        val2_n  = val2;
        carry_n = carry_out;
        stall   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    typ_n = shift_type;
                    if (val_Rs == 8'd0) begin
                        val2_n  = val_Rm;
                        carry_n = carry_in;
                        state_n = ST_DONE;
                    end else if (shift_type == SH_ROR && val_Rs[4:0] == 5'd0) begin
                        val2_n  = val_Rm;
                        carry_n = val_Rm[DW-1];
                        state_n = ST_DONE;
                    end else begin
                        work_n  = val_Rm;
                        count_n = amt_n;
                        state_n = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                stall   = 1'b1;
                work_n  = sh_work;
                count_n = count - k;
                if (count_n == CW'(0)) begin
                    val2_n  = sh_work;
                    carry_n = sh_carry;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort wins over everything; published result is left untouched
        if (flush) begin
            state_n = ST_IDLE;
            count_n = CW'(0);
            val2_n  = val2;
            carry_n = carry_out;
        end
    end

    // State and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            work  <= '0;
            count <= '0;
            typ   <= SH_LSL;
        end else begin
            state <= state_n;
            work  <= work_n;
            count <= count_n;
            typ   <= typ_n;
        end
    end

    // Registered outputs, derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val2      <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            val2      <= val2_n;
            carry_out <= carry_n;
            done      <= (state_n == ST_DONE);
            busy      <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: doc/reg_shift_sequencer.md
# reg_shift_sequencer

Multi-cycle sequencer for ARM register-specified shifts (shifter_operand[4]=1, amount taken from Rs[7:0]), the case the combinational Val2 generator does not handle. Sits beside the Val2 generator in the EX stage: decode raises start, the block stalls the pipeline while it iteratively shifts val_Rm, then presents val2 and the shifter carry-out for one done cycle. Implements full ARM semantics for amounts 0 and ≥32.

## Interface
- STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE.
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- val_Rm  in  32  operand to shift.
- val_Rs  in  8  shift amount, Rs[7:0].
- carry_in  in  1  current CPSR C.
- stall  out  1  combinational: (IDLE && start && !flush) || SHIFT.
- busy  out  1  state != IDLE.
- done  out  1  high exactly in DONE.
- val2  out  32  result; held until next DONE.
- carry_out  out  1  shifter carry; held with val2.

## Operation
- States: IDLE, SHIFT, DONE. Reset: IDLE, val2=0, carry_out=0, done=0, busy=0, internal count=0.
- IDLE, start=1, flush=0: capture val_Rm, shift_type, carry_in; compute n from amt=val_Rs:
  - amt=0 (any type): val2=val_Rm, carry_out=carry_in, go to DONE.
  - LSL/LSR: n=min(amt,33).
  - ASR: n=min(amt,32).
  - ROR: if amt[4:0]=0: val2=val_Rm, carry_out=val_Rm[31], go to DONE; else n=amt[4:0].
  - n>0: load working register with val_Rm, count=n, go to SHIFT.
- SHIFT, each cycle: k=min(STEP,count); shift working register by k (LSL zero-fill, LSR zero-fill, ASR sign-fill, ROR rotate); carry = last bit shifted out (for ROR, new bit 31); count -= k. When count reaches 0, write val2/carry_out on that edge and go to DONE.
- Resulting identities: LSL/LSR by 32 → 0, carry=Rm[0]/Rm[31]; by ≥33 → 0, carry=0; ASR ≥32 → all Rm[31], carry=Rm[31].
- DONE: done=1 for one cycle; unconditionally return to IDLE. A start in DONE is ignored.
- start in SHIFT or DONE: ignored, no queuing.
- flush: IDLE next edge from any state, overrides start; done not raised; val2/carry_out keep previous values.
- rst_n low at any time: immediate return to reset values, mid-shift data discarded.

## Timing
- Start sampled at edge E0. Zero-work cases (amt=0, ROR multiple of 32): DONE in cycle after E0 (latency 1).
- Otherwise SHIFT lasts ceil(n/STEP) cycles; done high in cycle E0+ceil(n/STEP)+1.
- stall high from start cycle through last SHIFT cycle; low in DONE so the stage advances with val2 valid.
- val2, carry_out, done, busy are registered; only stall is combinational.
- Worst case STEP=1: LSL/LSR 33 SHIFT cycles, latency 34.

## Test plan
- STEP=1, LSL, Rm=0x8000000F, Rs=4, C=1 → stall 5 cycles, done at cycle 5, val2=0x000000F0, carry_out=0.
- STEP=1, LSR Rs=32 on Rm=0x80000001 → done at 33, val2=0, carry=1; LSR Rs=40 → done at 34, val2=0, carry=0.
- STEP=4, ASR Rm=0x80000000, Rs=200 → n=32, done at 9, val2=0xFFFFFFFF, carry=1.
- STEP=4, ROR Rm=0x12345678, Rs=8 → done at 3, val2=0x78123456, carry=0; ROR Rs=32 → done at 1, val2=0x12345678, carry=0.
- Rs=0, C=1, any type, Rm=0xDEADBEEF → done at 1, val2=0xDEADBEEF, carry=1, stall only in start cycle.
- Start during SHIFT ignored (single done); flush in SHIFT → IDLE next cycle, no done, val2 unchanged; rst_n low mid-SHIFT → all outputs 0 immediately.
